// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: states, opcodes, ALU selects
// and the bundled datapath control word.
package mc_pkg;

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_EXECUTE   = 4'd6;
  localparam logic [3:0] S_ALU_WB    = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;

  localparam logic [4:0] OP_RTYPE = 5'b01100;
  localparam logic [4:0] OP_LW    = 5'b00000;
  localparam logic [4:0] OP_SW    = 5'b01000;
  localparam logic [4:0] OP_BEQ   = 5'b11000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_source;
    logic       mem_to_reg;
    logic       reg_write;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/mc_output_decode.sv
// Moore output decode: control word from the current state, with mem_ready
// qualifying only the memory-completion strobes.
import mc_pkg::*;

module mc_output_decode (
  input  logic [3:0] state_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      // Branch target is precomputed into ALUOut here.
      S_DECODE: begin
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEM_READ: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.iord       = 1'b1;
        ctrl_o.instr_done = mem_ready_i;
      end
      S_EXECUTE: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_RS2;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      S_ALU_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_RS2;
        ctrl_o.alu_op        = ALU_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = 1'b1;
        ctrl_o.instr_done    = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V style main controller: state register, next-state logic,
// and reset gating of the decoded control word.
import mc_pkg::*;

module multicycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] Inst_6_2,
  input  logic       mem_ready,
  output logic [1:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       PCSource,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       illegal_inst,
  output logic       instr_done,
  output logic [3:0] state
);

  logic [3:0] state_q, state_d;
  logic       illegal_d;
  ctrl_t      dec, ctrl;

  always_comb begin
    state_d   = S_FETCH;
    illegal_d = 1'b0;
    case (state_q)
      S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Inst_6_2)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR:  state_d = (Inst_6_2 == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_EXECUTE:   state_d = S_ALU_WB;
      default:     state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  mc_output_decode u_dec (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .ctrl_o      (dec)
  );

  // Reset silences everything, including FETCH's unconditional MemRead.
  assign ctrl = rst ? '0 : dec;

  assign ALUOp        = ctrl.alu_op;
  assign ALUSrcA      = ctrl.alu_src_a;
  assign ALUSrcB      = ctrl.alu_src_b;
  assign IorD         = ctrl.iord;
  assign MemRead      = ctrl.mem_read;
  assign MemWrite     = ctrl.mem_write;
  assign IRWrite      = ctrl.ir_write;
  assign PCWrite      = ctrl.pc_write;
  assign PCWriteCond  = ctrl.pc_write_cond;
  assign PCSource     = ctrl.pc_source;
  assign MemtoReg     = ctrl.mem_to_reg;
  assign RegWrite     = ctrl.reg_write;
  assign illegal_inst = ~rst & illegal_d;
  assign instr_done   = ~rst & (ctrl.instr_done | illegal_d);
  assign state        = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control with hand-computed expectations.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Inst_6_2;
  logic       mem_ready;
  logic [1:0] ALUOp, ALUSrcB;
  logic       ALUSrcA, IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond;
  logic       PCSource, MemtoReg, RegWrite, illegal_inst, instr_done;
  logic [3:0] state;

  int total = 0;
  int bad   = 0;

  multicycle_control dut (
    .clk(clk), .rst(rst), .Inst_6_2(Inst_6_2), .mem_ready(mem_ready),
    .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .PCSource(PCSource), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .illegal_inst(illegal_inst), .instr_done(instr_done),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-run tallies, filled by run_instr.
  int cyc, n_rd_iord, n_mw, n_rw, n_done, n_ill, n_pcwc, n_pcw, n_irw, n_fetch_four;
  int aop_exec, aop_br, srcsel_br, m2r_wb, st_trace [16];

  // Runs one instruction starting in FETCH; mem_ready is held low for the first
  // nwait cycles spent in state wst. Ends one cycle after instr_done.
  task automatic run_instr(input logic [4:0] op, input logic [3:0] wst, input int nwait);
    int waited = 0;
    bit done = 0;
    cyc = 0; n_rd_iord = 0; n_mw = 0; n_rw = 0; n_done = 0; n_ill = 0;
    n_pcwc = 0; n_pcw = 0; n_irw = 0; n_fetch_four = 0;
    aop_exec = -1; aop_br = -1; srcsel_br = -1; m2r_wb = -1;
    Inst_6_2 = op;
    for (int k = 0; k < 40 && !done; k++) begin
      if (state == wst && waited < nwait) begin
        mem_ready = 1'b0;
        waited++;
      end else begin
        mem_ready = 1'b1;
      end
      #1;
      if (k < 16) st_trace[k] = int'(state);
      cyc++;
      if (MemRead && IorD) n_rd_iord++;
      if (MemWrite) n_mw++;
      if (RegWrite) n_rw++;
      if (illegal_inst) n_ill++;
      if (PCWriteCond) n_pcwc++;
      if (PCWrite) n_pcw++;
      if (IRWrite) n_irw++;
      if (state == 4'd0 && ALUSrcB == 2'b01) n_fetch_four++;
      if (state == 4'd6) aop_exec = int'(ALUOp);
      if (state == 4'd8) begin aop_br = int'(ALUOp); srcsel_br = int'(PCSource); end
      if (state == 4'd4) m2r_wb = int'(MemtoReg);
      if (instr_done) begin n_done++; done = 1; end
      @(posedge clk);
      #1;
    end
    if (!done) chk("run_timeout", 0, 1);
    mem_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; mem_ready = 1'b1; Inst_6_2 = 5'b01100;
    tick(); tick();
    chk("rst_state", int'(state), 0);
    chk("rst_memread", int'(MemRead), 0);
    chk("rst_pcwrite", int'(PCWrite), 0);
    chk("rst_alusrcb", int'(ALUSrcB), 0);
    chk("rst_done", int'(instr_done), 0);
    rst = 1'b0; #1;
    chk("fetch_memread", int'(MemRead), 1);
    chk("fetch_srcb", int'(ALUSrcB), 1);

    // R-type, no waits
    run_instr(5'b01100, 4'd15, 0);
    chk("r_cycles", cyc, 4);
    chk("r_tr1", st_trace[1], 1);
    chk("r_tr2", st_trace[2], 6);
    chk("r_tr3", st_trace[3], 7);
    chk("r_aluop", aop_exec, 2);
    chk("r_regwrite", n_rw, 1);
    chk("r_done", n_done, 1);
    chk("r_back_fetch", int'(state), 0);

    // lw, two waits in MEM_READ
    run_instr(5'b00000, 4'd3, 2);
    chk("lw_cycles", cyc, 7);
    chk("lw_rd_iord", n_rd_iord, 3);
    chk("lw_memtoreg", m2r_wb, 1);
    chk("lw_regwrite", n_rw, 1);
    chk("lw_tr2", st_trace[2], 2);

    // sw then beq back to back
    run_instr(5'b01000, 4'd15, 0);
    chk("sw_cycles", cyc, 4);
    chk("sw_memwrite", n_mw, 1);
    chk("sw_regwrite", n_rw, 0);
    run_instr(5'b11000, 4'd15, 0);
    chk("beq_cycles", cyc, 3);
    chk("beq_aluop", aop_br, 1);
    chk("beq_pcwc", n_pcwc, 1);
    chk("beq_pcsrc", srcsel_br, 1);

    // illegal opcode
    run_instr(5'b11111, 4'd15, 0);
    chk("ill_cycles", cyc, 2);
    chk("ill_pulse", n_ill, 1);
    chk("ill_rw_mw", n_rw + n_mw + n_pcwc, 0);
    chk("ill_back_fetch", int'(state), 0);

    // FETCH waits for 3 cycles
    run_instr(5'b01100, 4'd0, 3);
    chk("fw_cycles", cyc, 7);
    chk("fw_pcwrite", n_pcw, 1);
    chk("fw_irwrite", n_irw, 1);
    chk("fw_srcb_four", n_fetch_four, 4);

    // mem_ready ignored in EXECUTE
    run_instr(5'b01100, 4'd6, 2);
    chk("ex_ignore_rdy", cyc, 4);

    // reset while stalled in MEM_WRITE
    Inst_6_2 = 5'b01000; mem_ready = 1'b1;
    tick(); tick(); tick();
    mem_ready = 1'b0; #1;
    chk("mw_state", int'(state), 5);
    chk("mw_memwrite", int'(MemWrite), 1);
    rst = 1'b1; #1;
    chk("mw_rst_memwrite", int'(MemWrite), 0);
    chk("mw_rst_done", int'(instr_done), 0);
    tick();
    chk("mw_rst_state", int'(state), 0);
    chk("mw_rst_memread", int'(MemRead), 0);
    rst = 1'b0; #1;
    chk("mw_refetch", int'(MemRead), 1);
    chk("mw_refetch_st", int'(state), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Port clk, input, 1: single rising-edge clock for all state.
REQ-002 Port rst, input, 1: reset, synchronous to clk and active-high.
REQ-003 Port Inst_6_2, input, 5: opcode bits [6:2] taken from the held IR.
REQ-004 Port mem_ready, input, 1: memory completes the current access this cycle.
REQ-005 Port ALUOp, output, 2: to the ALU control unit (00 add, 01 sub, 10 funct-decoded).
REQ-006 Port ALUSrcA, output, 1: 0 = OldPC, 1 = rs1.
REQ-007 Port ALUSrcB, output, 2: 00 = rs2, 01 = constant 4, 10 = immediate.
REQ-008 Ports IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond, PCSource, MemtoReg, RegWrite, output, 1 each: datapath strobes and selects.
REQ-009 Port illegal_inst, output, 1: one-cycle pulse for an unrecognised opcode.
REQ-010 Port instr_done, output, 1: one-cycle pulse in the final cycle of each instruction.
REQ-011 Port state, output, 4: current state encoding, for debug.

Function
REQ-012 Moore FSM: all outputs are decoded from the state, plus mem_ready where stated; every output not listed for a state is 0.
REQ-013 Recognised opcodes:
  - R-type 01100
  - lw 00000
  - sw 01000
  - beq 11000
REQ-014 FETCH:
  - outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=0
  - IRWrite = PCWrite = mem_ready
  - next state: DECODE if mem_ready, else stay in FETCH
REQ-015 DECODE:
  - outputs: ALUSrcA=0, ALUSrcB=10, ALUOp=00 (branch target into ALUOut)
  - next state by opcode: lw/sw -> MEM_ADDR, R-type -> EXECUTE, beq -> BRANCH
  - any other opcode -> FETCH, with illegal_inst=1 and instr_done=1
REQ-016 MEM_ADDR:
  - outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=00
  - next state: MEM_READ if lw, MEM_WRITE if sw
REQ-017 MEM_READ:
  - outputs: MemRead=1, IorD=1
  - next state: MEM_WB on mem_ready, else hold
REQ-018 MEM_WB:
  - outputs: RegWrite=1, MemtoReg=1, instr_done=1
  - next state: FETCH
REQ-019 MEM_WRITE:
  - outputs: MemWrite=1, IorD=1
  - instr_done = mem_ready
  - next state: FETCH on mem_ready, else hold
REQ-020 EXECUTE:
  - outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=10
  - next state: ALU_WB
REQ-021 ALU_WB:
  - outputs: RegWrite=1, MemtoReg=0, instr_done=1
  - next state: FETCH
REQ-022 BRANCH:
  - outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=1, instr_done=1
  - next state: FETCH
REQ-023 Latency with mem_ready held at 1, in cycles from entering FETCH through the instr_done cycle:
  - R-type 4
  - lw 5
  - sw 4
  - beq 3
  - illegal 2
  - each cycle with mem_ready=0 in a waiting state adds one cycle.
REQ-024 Memory handshake:
  - MemRead/MemWrite stay asserted, with constant IorD, until the cycle in which mem_ready=1.
  - mem_ready is ignored in every non-memory state.
REQ-025 Inst_6_2 is sampled only in DECODE and MEM_ADDR; changes in any other state have no effect.
REQ-026 Exactly one state is active per cycle; the state field has 9 legal encodings.
  - Any other encoding returns to FETCH on the next edge, with all strobes 0.

Reset
REQ-027 rst=1 at a clock edge forces state=FETCH on that edge, regardless of the current state or mem_ready.
REQ-028 While rst=1, all strobes are forced to 0, including the FETCH MemRead, and so are illegal_inst and instr_done.
  - ALUOp=00, ALUSrcA=0, ALUSrcB=00.
REQ-029 Reset mid-instruction abandons the instruction: no RegWrite, MemWrite, PCWrite or instr_done is issued for it.
  - Fetch restarts in the first cycle after rst deasserts.

Structure
REQ-030 Shared package mc_pkg holds:
  - the state encodings (FETCH=0 ... BRANCH=8)
  - the opcode constants
  - the ALUOp constants (ALU_ADD=00, ALU_SUB=01, ALU_FUNCT=10)
  - the ALUSrcB select constants
  - the ALU control unit imports the same ALUOp constants.
REQ-031 The design is one state register plus next-state logic.
  - Output decode is a natural sub-module, mc_output_decode: purely combinational, taking state and mem_ready.

Verification
REQ-032 Reset, then R-type 01100 with mem_ready=1:
  - state sequence 0,1,6,7,0
  - ALUOp=10 in EXECUTE
  - RegWrite=1 only in ALU_WB
  - instr_done once.
REQ-033 lw 00000 with mem_ready low for 2 cycles in MEM_READ:
  - MemRead=1, IorD=1 held 3 cycles
  - MEM_WB has MemtoReg=1
  - total 7 cycles.
REQ-034 sw 01000 and beq 11000, back to back:
  - sw: MemWrite pulse 1 cycle
  - beq: ALUOp=01, PCWriteCond=1, PCSource=1 in BRANCH
  - totals 4 and 3 cycles.
REQ-035 Opcode 11111:
  - illegal_inst=1 for one cycle in DECODE
  - return to FETCH
  - no RegWrite, MemWrite or PCWriteCond.
REQ-036 rst asserted in MEM_WRITE with mem_ready=0:
  - next state FETCH
  - MemWrite=0 from that edge, no instr_done
  - FETCH asserts MemRead=1 the cycle after rst drops.
REQ-037 FETCH with mem_ready=0 for 3 cycles:
  - PCWrite=0 and IRWrite=0 throughout
  - both =1 in the mem_ready cycle
  - ALUSrcB=01 throughout.
